// File: rtl/fibo_dp_pkg.sv
// Shared widths and ALU opcode encodings for the Fibonacci controller/datapath pair.
// Combinational constants only; no latency and no flow control.
package fibo_dp_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_PASS = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
    localparam logic [OP_W-1:0] OP_AND  = 3'b011;
    localparam logic [OP_W-1:0] OP_OR   = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_INC  = 3'b110;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b111;

endpackage

// File: rtl/fibo_alu.sv
// 8-function ALU with carry/borrow; FIBO_DP_SAT_EN turns wrap into saturation.
// Purely combinational, zero latency, no backpressure.
module fibo_alu
    import fibo_dp_pkg::*;
#(
    parameter int DATA_W = fibo_dp_pkg::DATA_W,
    parameter int OP_W   = fibo_dp_pkg::OP_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] result,
    output logic              c
);

    logic [DATA_W:0] sum_ext;
    logic [DATA_W:0] diff_ext;
    logic [DATA_W-1:0] inc_val;
    logic [DATA_W-1:0] dec_val;

    // Extra MSB of the extended sum/difference is the carry-out/borrow.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign inc_val  = a + 1'b1;
    assign dec_val  = a - 1'b1;

    always_comb begin
        result = '0;
        c      = 1'b0;
        case (opcode)
            OP_PASS: result = a;
            OP_ADD: begin
                result = sum_ext[DATA_W-1:0];
                c      = sum_ext[DATA_W];
            end
            OP_SUB: begin
                result = diff_ext[DATA_W-1:0];
                c      = diff_ext[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_INC: begin
                result = inc_val;
                c      = &a;
            end
            OP_DEC: begin
                result = dec_val;
                c      = ~|a;
            end
            default: begin
                result = '0;
                c      = 1'b0;
            end
        endcase
`ifdef FIBO_DP_SAT_EN
        // Clamp toward the bound that was crossed; c still flags the event.
        if (c) begin
            if (opcode == OP_ADD || opcode == OP_INC) begin
                result = '1;
            end else if (opcode == OP_SUB || opcode == OP_DEC) begin
                result = '0;
            end
        end
`endif
    end

endmodule

// File: rtl/fibo_datapath.sv
// Fibonacci datapath: 4-entry regfile, ALU, registered flags and result (FIBO_DP_SAT_EN selects saturating ALU).
// Writes, flags and data_out land one cycle after the edge; no backpressure, one transfer per clock.
module fibo_datapath
    import fibo_dp_pkg::*;
#(
    parameter int DATA_W = fibo_dp_pkg::DATA_W,
    parameter int ADDR_W = fibo_dp_pkg::ADDR_W,
    parameter int OP_W   = fibo_dp_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_data,
    input  logic              wrt_en,
    input  logic [ADDR_W-1:0] wrt_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [OP_W-1:0]   alu_opcode,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic [DATA_W-1:0] data_out
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_c;
    logic [DATA_W-1:0] wr_dat;

    // Combinational reads see the pre-edge contents, giving old-data read-during-write.
    assign op_a   = regs[rd_addr1];
    assign op_b   = regs[rd_addr2];
    assign wr_dat = load_data ? data_in : alu_result;

    fibo_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .opcode (alu_opcode),
        .result (alu_result),
        .c      (alu_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            data_out   <= '0;
        end else begin
            data_out <= alu_result;
            if (wrt_en) begin
                regs[wrt_addr] <= wr_dat;
                zero_flag      <= (wr_dat == '0);
                carry_flag     <= load_data ? 1'b0 : alu_c;
            end
        end
    end

endmodule

// File: tb/tb_fibo_datapath.sv
// Directed test-plan scenarios plus randomized traffic, checked each cycle against an arithmetic model.
module tb_fibo_datapath;
    import fibo_dp_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       load_data;
    logic       wrt_en;
    logic [1:0] wrt_addr;
    logic [1:0] rd_addr1;
    logic [1:0] rd_addr2;
    logic [2:0] alu_opcode;
    logic       zero_flag;
    logic       carry_flag;
    logic [7:0] data_out;

    int n_cmp = 0;
    int n_err = 0;

    int m_r [4];
    int m_out;
    bit m_z;
    bit m_c;

    fibo_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_data  (load_data),
        .wrt_en     (wrt_en),
        .wrt_addr   (wrt_addr),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .alu_opcode (alu_opcode),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from plain integer arithmetic.
    function automatic void alu_model(input int a, input int b, input int op,
                                      output int r, output bit c);
        r = 0;
        c = 1'b0;
        case (op)
            0: r = a;
            1: begin r = a + b; c = (r > 255); end
            2: begin r = a - b; c = (a < b); end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: begin r = a + 1; c = (a == 255); end
            7: begin r = a - 1; c = (a == 0); end
            default: r = 0;
        endcase
`ifdef FIBO_DP_SAT_EN
        if (c && (op == 1 || op == 6)) r = 255;
        if (c && (op == 2 || op == 7)) r = 0;
`endif
        r = r & 255;
    endfunction

    int cm_a, cm_b, cm_r, cm_w;
    bit cm_c;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_r[i] = 0;
            m_out = 0;
            m_z   = 1'b0;
            m_c   = 1'b0;
        end else begin
            cm_a = m_r[rd_addr1];
            cm_b = m_r[rd_addr2];
            alu_model(cm_a, cm_b, int'(alu_opcode), cm_r, cm_c);
            m_out = cm_r;
            if (wrt_en) begin
                cm_w = load_data ? int'(data_in) : cm_r;
                m_r[wrt_addr] = cm_w;
                m_z = (cm_w == 0);
                m_c = load_data ? 1'b0 : cm_c;
            end
        end
        #1;
        check("model data_out", data_out, m_out);
        check("model zero_flag", zero_flag, m_z);
        check("model carry_flag", carry_flag, m_c);
    end

    task automatic step(input bit r, input bit ld, input bit we, input int wa,
                        input int ra1, input int ra2, input logic [2:0] op, input int din);
        @(negedge clk);
        rst        = r;
        load_data  = ld;
        wrt_en     = we;
        wrt_addr   = 2'(wa);
        rd_addr1   = 2'(ra1);
        rd_addr2   = 2'(ra2);
        alu_opcode = op;
        data_in    = 8'(din);
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int wa, input int din);
        step(0, 1, 1, wa, 0, 0, OP_PASS, din);
    endtask

    task automatic peek(input int ra);
        step(0, 0, 0, 0, ra, 0, OP_PASS, 0);
    endtask

    int fib_exp [5];
    int exp_ovf;
    int exp_unf;

    initial begin
        fib_exp = '{1, 2, 3, 5, 8};
`ifdef FIBO_DP_SAT_EN
        exp_ovf = 255;
        exp_unf = 0;
`else
        exp_ovf = 44;
        exp_unf = 255;
`endif
        rst = 1'b1; load_data = 1'b1; wrt_en = 1'b1; wrt_addr = 2'd0;
        rd_addr1 = 2'd0; rd_addr2 = 2'd0; alu_opcode = OP_PASS; data_in = 8'h55;

        // Reset held two cycles with a write pending: write must be dropped.
        step(1, 1, 1, 0, 0, 0, OP_INC, 8'h55);
        step(1, 1, 1, 0, 0, 0, OP_INC, 8'h55);
        check("reset data_out", data_out, 0);
        check("reset zero_flag", zero_flag, 0);
        check("reset carry_flag", carry_flag, 0);
        peek(0);
        check("reset write dropped", data_out, 0);

        // Loads.
        load(0, 0);
        check("load R0 zero_flag", zero_flag, 1);
        load(1, 1);
        load(3, 5);
        check("load R3 zero_flag", zero_flag, 0);
        peek(3);
        check("R3 after load", data_out, 5);

        // Fibonacci loop.
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 2, 0, 1, OP_ADD, 0);
            step(0, 0, 1, 0, 1, 0, OP_PASS, 0);
            step(0, 0, 1, 1, 2, 0, OP_PASS, 0);
            step(0, 0, 1, 3, 3, 0, OP_DEC, 0);
            check("fib zero_flag after DEC", zero_flag, (i == 4));
            peek(1);
            check("fib R1", data_out, fib_exp[i]);
        end

        // Overflow.
        load(0, 200);
        load(1, 100);
        step(0, 0, 1, 2, 0, 1, OP_ADD, 0);
        check("ovf data_out", data_out, exp_ovf);
        check("ovf carry_flag", carry_flag, 1);
        peek(2);
        check("ovf R2", data_out, exp_ovf);

        // Underflow, then a non-writing cycle holds flags.
        load(3, 0);
        step(0, 0, 1, 3, 3, 0, OP_DEC, 0);
        check("unf data_out", data_out, exp_unf);
        check("unf carry_flag", carry_flag, 1);
        check("unf zero_flag", zero_flag, (exp_unf == 0));
        step(0, 0, 0, 3, 0, 1, OP_XOR, 0);
        check("hold carry_flag", carry_flag, 1);
        check("hold zero_flag", zero_flag, (exp_unf == 0));
        check("hold data_out updates", data_out, 200 ^ 100);

        // Read-during-write on R1.
        step(0, 1, 1, 1, 1, 1, OP_PASS, 9);
        check("rdw old R1", data_out, 100);
        peek(1);
        check("rdw new R1", data_out, 9);

        // Randomized traffic with occasional mid-sequence reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) == 0), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 4) == 0) ? 0 : (($urandom_range(0, 4) == 0) ? 255 : $urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fibo_datapath.md
Name: fibo_datapath

Overview:
- Datapath responder for the Fibonacci controller FSM.
- Consumes the controller's control bundle: wrt_addr, wrt_en, load_data, rd_addr1, rd_addr2, alu_opcode.
- Returns zero_flag, which the controller uses for loop termination.
- Contains a small synchronous register file, an 8-function ALU, registered status flags and a registered result port. It executes one register-transfer per clock.

Parameters:
- DATA_W, 8, width of data words, register file entries and ALU.
- ADDR_W, 2, register address width; must equal controller size-1.
- OP_W, 3, ALU opcode width; must equal controller size.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  external operand, written when load_data=1.
- load_data  in  1  write-source select: 1 = data_in, 0 = ALU result.
- wrt_en  in  1  register file write enable.
- wrt_addr  in  ADDR_W  write address.
- rd_addr1  in  ADDR_W  ALU operand A address.
- rd_addr2  in  ADDR_W  ALU operand B address.
- alu_opcode  in  OP_W  ALU function select.
- zero_flag  out  1  1 when the last written word was zero.
- carry_flag  out  1  carry/borrow of the last ALU write.
- data_out  out  DATA_W  ALU result, registered every cycle.

Behaviour:
- Register file:
  - 2**ADDR_W entries of DATA_W bits.
  - Reads are combinational: A = R[rd_addr1], B = R[rd_addr2].
  - Write occurs on the rising edge when wrt_en=1: R[wrt_addr] <= load_data ? data_in : alu_result.
- Read-during-write to the same address: the read returns the old value in that cycle. The new value is visible from the next cycle.
- rd_addr1 == rd_addr2 is legal; both operands equal R[addr].
- ALU is combinational, modulo 2**DATA_W:
  - 000 PASS A
  - 001 A+B
  - 010 A-B
  - 011 A&B
  - 100 A|B
  - 101 A^B
  - 110 A+1
  - 111 A-1
- Carry (c) per opcode:
  - ADD: carry-out.
  - SUB: borrow, i.e. A<B unsigned.
  - INC: A == all-ones.
  - DEC: A == 0.
  - PASS and logic ops: c = 0.
- Flags are registered and update only on cycles with wrt_en=1; otherwise they hold.
  - zero_flag <= (written word == 0), for both load and ALU writes.
  - carry_flag <= load_data ? 0 : c.
- data_out <= alu_result every cycle, regardless of wrt_en.
- Latency:
  - Write data is visible on reads 1 cycle after the write edge.
  - Flags and data_out are valid 1 cycle after the edge.
- Reset:
  - When Rst=1 at an edge, all registers, zero_flag, carry_flag and data_out go to 0. Note that zero_flag resets to 0, not 1.
  - Reset has priority over wrt_en in the same cycle; that write is dropped.
  - Reset mid-sequence aborts cleanly with no partial state.
- X or unused opcodes: none; all 2**OP_W codes are defined.

Optional Feature:
- Macro: FIBO_DP_SAT_EN.
- When defined:
  - ADD and INC saturate to all-ones on overflow.
  - SUB and DEC saturate to 0 on underflow.
  - carry_flag still reports that saturation occurred.
- When undefined: modulo wrap as above.
- The zero_flag rule is unchanged in both cases.

Decomposition:
- Package fibo_dp_pkg holds:
  - Opcode localparams: OP_PASS, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INC, OP_DEC.
  - Default widths DATA_W, ADDR_W, OP_W, shared with the controller.
- Sub-module fibo_alu: combinational; inputs A, B and opcode; outputs result and c.
- The register file, flags and data_out register stay in fibo_datapath.

Test Plan:
- Reset: Rst=1 for 2 cycles with wrt_en=1 → all R=0, zero_flag=0, carry_flag=0, data_out=0; the write is dropped.
- Load: load R0=0 and R1=1, then load R3=5 → R3 reads 5 next cycle; zero_flag=0 after R3 load and 1 after R0 load.
- Fibonacci: R2=R0+R1, R0=R1, R1=R2, R3=R3-1 (DEC) repeated → R1 sequence 1,2,3,5,8; zero_flag=1 exactly after the 5th DEC write; the controller stops.
- Overflow: R0=200, R1=100, ADD → R2=44, carry_flag=1. With FIBO_DP_SAT_EN: R2=255, carry_flag=1.
- Underflow and hold: DEC on 0 → 255 (or 0 with SAT), carry_flag=1. A following cycle with wrt_en=0 leaves both flags unchanged while data_out still updates.
- Read-during-write: read and write R1 in the same cycle → data_out reflects the old R1; the next cycle reflects the new R1.
